intersection_phase_scheduler: RTL and testbench

Two-approach intersection sequencer that drives the north-south (NS) and east-west (EW) signal heads. It also serves vehicle-demand sensors and latched pedestrian requests. The block owns phase timing: minimum and maximum green, yellow clearance, all-red clearance and an optional pedestrian walk interval. Each lamp bus uses the light encoding standard across the codebase's controllers.

---
 rtl/intersection_phase_scheduler.sv | 158 +++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: two-approach (NS/EW) signal sequencer with
// min/max green, yellow and all-red clearance and a tick prescaler.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
// Lamp buses are one-hot: [2]=Red, [1]=Yellow, [0]=Green.
module intersection_phase_scheduler #(
  parameter int TICK_DIV  = 10000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_demand,
  input  logic       ew_demand,
  input  logic       ped_req,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [2:0] S_AR_TO_NS  = 3'd0;
  localparam logic [2:0] S_NS_GREEN  = 3'd1;
  localparam logic [2:0] S_NS_YELLOW = 3'd2;
  localparam logic [2:0] S_AR_TO_EW  = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_PED_WALK  = 3'd6;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Timer must hold the largest duration; prescaler must hold TICK_DIV-1.
  localparam int MAX_GY  = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int MAX_AW  = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int MAX_DUR = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int TW      = $clog2(MAX_DUR) + 1;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_SAT    = TW'(GREEN_MAX);
  localparam logic [TW:0]   E_ONE    = (TW+1)'(1);
  localparam logic [TW:0]   E_GMIN   = (TW+1)'(GREEN_MIN);
  localparam logic [TW:0]   E_GMAX   = (TW+1)'(GREEN_MAX);
  localparam logic [TW:0]   E_YELLOW = (TW+1)'(YELLOW_T);
  localparam logic [TW:0]   E_ALLRED = (TW+1)'(ALLRED_T);
  localparam logic [TW:0]   E_WALK   = (TW+1)'(WALK_T);

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [TW-1:0] timer;
  logic [TW:0]   elapsed;
  logic          target_ew;   // green to resume after a walk: 1=EW, 0=NS
  logic          ped_q;
  logic          enter_walk;

  assign tick       = (prescaler == PRE_LAST);
  assign elapsed    = {1'b0, timer} + E_ONE;
  assign enter_walk = (state_next == S_PED_WALK) && (state != S_PED_WALK);

  // Next-state decision, evaluated only on tick cycles.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    if (tick) begin
      case (state)
        S_AR_TO_NS:
          if (elapsed == E_ALLRED) state_next = ped_q ? S_PED_WALK : S_NS_GREEN;
        S_NS_GREEN:
          if ((elapsed >= E_GMIN) && (ew_demand || ped_q) &&
              (!ns_demand || (elapsed >= E_GMAX)))
            state_next = S_NS_YELLOW;
        S_NS_YELLOW:
          if (elapsed == E_YELLOW) state_next = S_AR_TO_EW;
        S_AR_TO_EW:
          if (elapsed == E_ALLRED) state_next = ped_q ? S_PED_WALK : S_EW_GREEN;
        S_EW_GREEN:
          if ((elapsed >= E_GMIN) && (ns_demand || ped_q) &&
              (!ew_demand || (elapsed >= E_GMAX)))
            state_next = S_EW_YELLOW;
        S_EW_YELLOW:
          if (elapsed == E_YELLOW) state_next = S_AR_TO_NS;
        S_PED_WALK:
          if (elapsed == E_WALK) state_next = target_ew ? S_EW_GREEN : S_NS_GREEN;
        default:
          state_next = S_AR_TO_NS;
      endcase
    end
  end

  // State, free-running prescaler, saturating per-state timer and walk target.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the edge) and sequential state uses <= only.
    if (!rst_n) begin
      state     <= S_AR_TO_NS;
      prescaler <= '0;
      timer     <= '0;
      target_ew <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      state     <= state_next;
      if (state_next != state) begin
        timer <= '0;
      end else if (tick && (timer != T_SAT)) begin
        timer <= timer + 1'b1;
      end
      if (enter_walk) begin
        target_ew <= (state == S_AR_TO_EW);
      end
    end
  end

`ifdef PED_WALK_EN
  // Pedestrian request latch; a new press on the walk-entry edge wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_q <= 1'b0;
    end else if (ped_req) begin
      ped_q <= 1'b1;
    end else if (enter_walk) begin
      ped_q <= 1'b0;
    end
  end

  assign walk = (state == S_PED_WALK);
`else
  logic ped_req_unused;
  assign ped_req_unused = ped_req;
  assign ped_q          = 1'b0;
  assign walk           = 1'b0;
`endif

  assign ped_pending = ped_q;
  assign phase       = state;

  // Lamp decode straight from the registered state; anything not green/yellow is red.
  always_comb begin
    ns_lights = LAMP_RED;
    ew_lights = LAMP_RED;
    case (state)
      S_NS_GREEN:  ns_lights = LAMP_GREEN;
      S_NS_YELLOW: ns_lights = LAMP_YELLOW;
      S_EW_GREEN:  ew_lights = LAMP_GREEN;
      S_EW_YELLOW: ew_lights = LAMP_YELLOW;
      default: begin
        ns_lights = LAMP_RED;
        ew_lights = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed testbench for intersection_phase_scheduler. Main instance uses
// TICK_DIV=1, GREEN_MIN=2, GREEN_MAX=4, YELLOW_T=2, ALLRED_T=1, WALK_T=3;
// a second instance with TICK_DIV=3 exercises the prescaler.
// Pedestrian scenarios are compiled only when PED_WALK_EN is defined.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_demand = 1'b0;
  logic       ew_demand = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_lights, ew_lights, phase;
  logic       walk, ped_pending;
  logic [2:0] d3_ns_lights, d3_ew_lights, d3_phase;
  logic       d3_walk, d3_ped_pending;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .TICK_DIV(1), .GREEN_MIN(2), .GREEN_MAX(4),
    .YELLOW_T(2), .ALLRED_T(1), .WALK_T(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ns_demand(ns_demand), .ew_demand(ew_demand),
    .ped_req(ped_req), .ns_lights(ns_lights), .ew_lights(ew_lights),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  intersection_phase_scheduler #(
    .TICK_DIV(3), .GREEN_MIN(2), .GREEN_MAX(4),
    .YELLOW_T(2), .ALLRED_T(1), .WALK_T(3)
  ) dut_div3 (
    .clk(clk), .rst_n(rst_n), .ns_demand(ns_demand), .ew_demand(ew_demand),
    .ped_req(ped_req), .ns_lights(d3_ns_lights), .ew_lights(d3_ew_lights),
    .walk(d3_walk), .ped_pending(d3_ped_pending), .phase(d3_phase)
  );

  // Expected {ns_lights, ew_lights} for a phase code, from the lamp table.
  function automatic logic [5:0] lamps(input logic [2:0] p);
    case (p)
      3'd1:    lamps = 6'b001_100;
      3'd2:    lamps = 6'b010_100;
      3'd4:    lamps = 6'b100_001;
      3'd5:    lamps = 6'b100_010;
      default: lamps = 6'b100_100;
    endcase
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given demand levels, then release.
  task automatic apply_reset(input logic ns, input logic ew);
    rst_n = 1'b0;
    ns_demand = ns;
    ew_demand = ew;
    ped_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ns_demand = 1'b0;
    ew_demand = 1'b0;
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    cycle();
    vectors++;
    if ({phase, ns_lights, ew_lights, walk, ped_pending} !== {3'd0, 6'b100_100, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got phase=%0d ns=%b ew=%b walk=%b pp=%b, want 0 100 100 0 0",
               phase, ns_lights, ew_lights, walk, ped_pending);
    end
    vectors++;
    if ({d3_phase, d3_ns_lights, d3_ew_lights, d3_walk, d3_ped_pending} !== {3'd0, 6'b100_100, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state_div3: got phase=%0d ns=%b ew=%b, want 0 100 100",
               d3_phase, d3_ns_lights, d3_ew_lights);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      cycle();
      vectors++;
      if ({phase, ns_lights, ew_lights} !== {3'd1, lamps(3'd1)}) begin
        miscompares++;
        $display("FAIL no_demand_rest edge %0d: got phase=%0d ns=%b ew=%b, want 1 001 100",
                 k, phase, ns_lights, ew_lights);
      end
    end
  endtask

  task automatic test_ew_demand();
    logic [2:0] exp_seq [6] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
    logic [2:0] exp_p;
    apply_reset(1'b0, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      cycle();
      exp_p = (k <= 6) ? exp_seq[k-1] : 3'd4;
      vectors++;
      if ({phase, ns_lights, ew_lights} !== {exp_p, lamps(exp_p)}) begin
        miscompares++;
        $display("FAIL ew_demand edge %0d: got phase=%0d ns=%b ew=%b, want phase=%0d lamps=%b",
                 k, phase, ns_lights, ew_lights, exp_p, lamps(exp_p));
      end
    end
  endtask

  task automatic test_prescaler();
    logic [2:0] exp_p;
    apply_reset(1'b0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      cycle();
      if (k < 3)       exp_p = 3'd0;
      else if (k < 9)  exp_p = 3'd1;
      else if (k < 15) exp_p = 3'd2;
      else if (k < 18) exp_p = 3'd3;
      else             exp_p = 3'd4;
      vectors++;
      if ({d3_phase, d3_ns_lights, d3_ew_lights} !== {exp_p, lamps(exp_p)}) begin
        miscompares++;
        $display("FAIL prescaler_div3 edge %0d: got phase=%0d, want %0d", k, d3_phase, exp_p);
      end
    end
  endtask

  task automatic test_both_demand();
    logic [2:0] period [14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                                3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};
    logic [2:0] exp_p;
    apply_reset(1'b1, 1'b1);
    for (int k = 1; k <= 42; k++) begin
      cycle();
      exp_p = period[(k-1) % 14];
      vectors++;
      if ({phase, ns_lights, ew_lights} !== {exp_p, lamps(exp_p)}) begin
        miscompares++;
        $display("FAIL both_demand edge %0d: got phase=%0d ns=%b ew=%b, want phase=%0d",
                 k, phase, ns_lights, ew_lights, exp_p);
      end
      vectors++;
      if ((ns_lights != 3'b100) && (ew_lights != 3'b100)) begin
        miscompares++;
        $display("FAIL both_heads_open edge %0d: got ns=%b ew=%b, want at least one 100",
                 k, ns_lights, ew_lights);
      end
    end
  endtask

`ifdef PED_WALK_EN
  task automatic test_ped_walk();
    logic [2:0] exp_p [10] = '{3'd2, 3'd2, 3'd3, 3'd6, 3'd6, 3'd6, 3'd4, 3'd4, 3'd4, 3'd4};
    logic       exp_pp [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset(1'b0, 1'b0);
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    vectors++;
    if ({phase, walk, ped_pending} !== {3'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL ped_latch: got phase=%0d walk=%b pp=%b, want 1 0 1", phase, walk, ped_pending);
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      vectors++;
      if ({phase, ns_lights, ew_lights, walk, ped_pending} !==
          {exp_p[k], lamps(exp_p[k]), exp_p[k] == 3'd6, exp_pp[k]}) begin
        miscompares++;
        $display("FAIL ped_walk edge %0d: got phase=%0d ns=%b ew=%b walk=%b pp=%b, want phase=%0d pp=%b",
                 k + 3, phase, ns_lights, ew_lights, walk, ped_pending, exp_p[k], exp_pp[k]);
      end
    end
  endtask

  task automatic test_ped_on_entry();
    logic [2:0] exp_p [11] = '{3'd6, 3'd6, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd6, 3'd6, 3'd6, 3'd1};
    logic       exp_pp [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset(1'b0, 1'b0);
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    cycle();
    cycle();
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    vectors++;
    if ({phase, walk, ped_pending} !== {3'd6, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL ped_set_wins: got phase=%0d walk=%b pp=%b, want 6 1 1", phase, walk, ped_pending);
    end
    for (int k = 0; k < 11; k++) begin
      cycle();
      vectors++;
      if ({phase, ns_lights, ew_lights, walk, ped_pending} !==
          {exp_p[k], lamps(exp_p[k]), exp_p[k] == 3'd6, exp_pp[k]}) begin
        miscompares++;
        $display("FAIL ped_second_walk edge %0d: got phase=%0d walk=%b pp=%b, want phase=%0d pp=%b",
                 k + 7, phase, walk, ped_pending, exp_p[k], exp_pp[k]);
      end
    end
  endtask
`else
  task automatic test_ped_ignored();
    apply_reset(1'b0, 1'b0);
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      vectors++;
      if ({phase, walk, ped_pending} !== {3'd1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL ped_ignored cycle %0d: got phase=%0d walk=%b pp=%b, want 1 0 0",
                 k, phase, walk, ped_pending);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_phase();
    logic exp_pp;
`ifdef PED_WALK_EN
    exp_pp = 1'b1;
`else
    exp_pp = 1'b0;
`endif
    apply_reset(1'b1, 1'b1);
    for (int k = 1; k <= 11; k++) cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    vectors++;
    if ({phase, ns_lights, ew_lights, ped_pending} !== {3'd5, lamps(3'd5), exp_pp}) begin
      miscompares++;
      $display("FAIL pre_reset_yellow: got phase=%0d ew=%b pp=%b, want 5 010 %b",
               phase, ew_lights, ped_pending, exp_pp);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    vectors++;
    if ({phase, ns_lights, ew_lights, walk, ped_pending} !== {3'd0, 6'b100_100, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_mid_phase: got phase=%0d ns=%b ew=%b walk=%b pp=%b, want 0 100 100 0 0",
               phase, ns_lights, ew_lights, walk, ped_pending);
    end
    for (int k = 1; k <= 5; k++) begin
      cycle();
      vectors++;
      if (phase !== ((k <= 4) ? 3'd1 : 3'd2)) begin
        miscompares++;
        $display("FAIL restart_after_reset edge %0d: got phase=%0d, want %0d",
                 k, phase, (k <= 4) ? 1 : 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ew_demand();
    test_prescaler();
    test_both_demand();
`ifdef PED_WALK_EN
    test_ped_walk();
    test_ped_on_entry();
`else
    test_ped_ignored();
`endif
    test_reset_mid_phase();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
